psum_collector: RTL
===================

PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 SHALL have parameter BW2, default 16: width of the signed partial sum arriving from the last PE of a column.
REQ-002 SHALL have parameter OW, default 24: signed accumulated output width; OW >= BW2.
REQ-003 SHALL have parameter K, default 4: partial sums summed per output word; K >= 1.
REQ-004 SHALL have parameter DEPTH, default 4: output FIFO entries; power of two, >= 2.
REQ-005 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-006 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-007 i_start  input  1  one-cycle pulse; starts a job; sampled only in IDLE.
REQ-008 i_nout  input  8  number of output words in the job; sampled with i_start; 0 is treated as 1.
REQ-009 i_psum  input  BW2  signed partial sum from the PE register output.
REQ-010 i_psum_vld  input  1  i_psum is valid this cycle; no backpressure toward the PE.
REQ-011 o_data  output  OW  FIFO head word, signed.
REQ-012 o_valid  output  1  FIFO is not empty.
REQ-013 i_ready  input  1  downstream accepts o_data when o_valid && i_ready.
REQ-014 o_busy  output  1  high in ACC and DONE states.
REQ-015 o_done  output  1  one-cycle pulse after the last word of the job is pushed.
REQ-016 o_sat  output  1  sticky: some output word saturated; cleared on an accepted i_start.
REQ-017 o_ovf  output  1  sticky: a word was dropped because the FIFO was full; cleared on an accepted i_start.

Function
REQ-018 SHALL implement FSM states IDLE, ACC, DONE: IDLE->ACC on i_start; ACC->DONE on push of word i_nout; DONE->IDLE unconditionally after one cycle.
REQ-019 On accepting i_start, SHALL clear acc, term count, word count, o_sat and o_ovf.
REQ-020 In ACC, each cycle with i_psum_vld SHALL add sign-extended i_psum to acc; i_psum_vld SHALL be ignored in IDLE and DONE.
REQ-021 On the K-th valid term, SHALL push saturate(acc + i_psum) to the FIFO in that same cycle, then clear acc and term count (the term count wraps to 0).
REQ-022 Saturation SHALL clamp to [-2^(OW-1), 2^(OW-1)-1] on the final sum only; any clamping SHALL set o_sat.
REQ-023 A pushed word SHALL appear on o_data/o_valid on the cycle after the push (1-cycle latency) when the FIFO was empty.
REQ-024 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full.
REQ-025 A push to a full FIFO without a simultaneous pop SHALL drop the word and set o_ovf; the dropped word SHALL still count toward i_nout.
REQ-026 A pop on an empty FIFO SHALL not occur (o_valid low); FIFO pointers SHALL wrap modulo DEPTH.
REQ-027 o_done SHALL be high for exactly the DONE cycle; o_busy SHALL be low in IDLE.
REQ-028 i_start while o_busy SHALL be ignored, with no effect on state, counts or flags.
REQ-029 The FIFO SHALL keep draining in every state, including IDLE after the job ends.

Reset
REQ-030 Asserting i_rst_n low SHALL immediately force: state IDLE; acc, all counts and FIFO pointers zero; o_valid=0, o_busy=0, o_done=0, o_sat=0, o_ovf=0, o_data=0.
REQ-031 Reset mid-job SHALL discard the accumulator and all FIFO contents; no word SHALL be emitted after release until a new job is started.

Structure
REQ-032 FSM state encoding and the saturation helper SHALL live in the shared package pe_pkg.
REQ-033 The FIFO SHALL be a separate sub-module, sync_fifo (parameters W, DEPTH; full/empty flags; simultaneous push and pop).

Verification
REQ-034 K=4, i_nout=2, psums 1,2,3,4,5,6,7,8 on consecutive cycles, i_ready=1 -> outputs 10 then 26; o_done pulses once; o_sat=0, o_ovf=0.
REQ-035 BW2=16, OW=16, K=2, psums 32767,32767 -> output 32767 and o_sat=1; psums -32768,-1 -> output -32768.
REQ-036 DEPTH=4, K=1, i_nout=6, i_ready=0 -> 4 words held, o_ovf=1, o_done pulses; then i_ready=1 -> exactly the first 4 words in order.
REQ-037 FIFO full with i_ready=1 and a push in the same cycle -> no drop, o_ovf stays 0, FIFO remains full.
REQ-038 Assert reset after 2 of 4 terms of K=4, then release and start a new job with psums 1,1,1,1 -> single output 4 with no residue.
REQ-039 i_psum_vld gaps (valid on cycles 0,3,4,9) with K=4 -> one output equal to the sum of those four terms; i_start pulsed mid-job -> ignored.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared FSM encoding and saturation helpers for the partial-sum collector.
package pe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned SAT_W = 64;

    // Largest positive value representable in an ow-bit signed word.
    function automatic logic signed [SAT_W-1:0] sat_max(input int unsigned ow);
        return (64'sd1 <<< (ow - 1)) - 64'sd1;
    endfunction

    function automatic logic sat_hit(input logic signed [SAT_W-1:0] v,
                                     input int unsigned ow);
        return (v > sat_max(ow)) || (v < -sat_max(ow) - 64'sd1);
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_clamp(input logic signed [SAT_W-1:0] v,
                                                          input int unsigned ow);
        if (v > sat_max(ow)) return sat_max(ow);
        if (v < -sat_max(ow) - 64'sd1) return -sat_max(ow) - 64'sd1;
        return v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; push and pop may coincide even when full.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]  wr_ptr_q, wr_ptr_d;
    logic [PW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         wr_en;
    logic         rd_en;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        o_empty  = (wr_ptr_q == rd_ptr_q);
        o_full   = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        wr_en    = i_push && (!o_full || i_pop);
        rd_en    = i_pop && !o_empty;
        if (wr_en) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        o_rdata  = o_empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];
    end

    // NOTE: state flops use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem_q[wr_ptr_q[PW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/psum_collector.sv
// Sums K signed partial sums per output word, saturates, and queues words for downstream.
module psum_collector
    import pe_pkg::*;
#(
    parameter int BW2   = 16,
    parameter int OW    = 24,
    parameter int K     = 4,
    parameter int DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [7:0]            i_nout,
    input  logic signed [BW2-1:0] i_psum,
    input  logic                  i_psum_vld,
    output logic signed [OW-1:0]  o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_sat,
    output logic                  o_ovf
);

    // Wide enough to hold the exact sum of K terms before the final clamp.
    localparam int AW = BW2 + $clog2(K) + 1;
    localparam int TW = (K > 1) ? $clog2(K) : 1;

    state_e                state_q, state_d;
    logic signed [AW-1:0]  acc_q, acc_d, sum;
    logic [TW-1:0]         term_q, term_d;
    logic [7:0]            word_q, word_d;
    logic [7:0]            nout_q, nout_d;
    logic                  sat_q, sat_d;
    logic                  ovf_q, ovf_d;
    logic                  last_term;
    logic                  push;
    logic                  pop;
    logic signed [OW-1:0]  push_data;
    logic                  fifo_full;
    logic                  fifo_empty;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        term_d    = term_q;
        word_d    = word_q;
        nout_d    = nout_q;
        sat_d     = sat_q;
        ovf_d     = ovf_q;
        push      = 1'b0;
        sum       = acc_q + AW'(i_psum);
        last_term = (term_q == TW'(K - 1));
        push_data = OW'(sat_clamp(SAT_W'(sum), OW));
        pop       = i_ready && !fifo_empty;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_ACC;
                    acc_d   = '0;
                    term_d  = '0;
                    word_d  = '0;
                    sat_d   = 1'b0;
                    ovf_d   = 1'b0;
                    nout_d  = (i_nout == 8'd0) ? 8'd1 : i_nout;
                end
            end
            ST_ACC: begin
                if (i_psum_vld) begin
                    if (last_term) begin
                        push   = 1'b1;
                        acc_d  = '0;
                        term_d = '0;
                        word_d = word_q + 8'd1;
                        if (sat_hit(SAT_W'(sum), OW)) sat_d = 1'b1;
                        // Dropped words still count, so the job always terminates.
                        if (({1'b0, word_q} + 9'd1) == {1'b0, nout_q}) state_d = ST_DONE;
                    end else begin
                        acc_d  = sum;
                        term_d = term_q + TW'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (push && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            term_q  <= '0;
            word_q  <= '0;
            nout_q  <= '0;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            term_q  <= term_d;
            word_q  <= word_d;
            nout_q  <= nout_d;
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
        end
    end

    sync_fifo #(
        .W     (OW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_wdata (push_data),
        .i_pop   (pop),
        .o_rdata (o_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_valid = !fifo_empty;
    assign o_busy  = (state_q != ST_IDLE);
    assign o_done  = (state_q == ST_DONE);
    assign o_sat   = sat_q;
    assign o_ovf   = ovf_q;

endmodule
